// File: rtl/fwd_scoreboard_unit_if.sv
// Interface for the EX-stage forwarding/hazard unit.
// The master side is the pipeline (drives the EX instruction fields) and
// the slave side is the scoreboard (returns operand-mux selects and stall).
// Optional statistics counters are present only when FWD_STATS_EN is defined.
interface fwd_scoreboard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 2
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                      exValid;
  logic                      exRegWrite;
  logic [REG_AW-1:0]         exRd;
  logic [LAT_W-1:0]          exLat;
  logic [NUM_SRC*REG_AW-1:0] exRs;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwdSel;
  logic                      stall;
`ifdef FWD_STATS_EN
  logic [31:0]               stallCnt;
  logic [31:0]               fwdCnt;
`endif

  modport master (
    output exValid, exRegWrite, exRd, exLat, exRs, flush,
    input  fwdSel, stall
`ifdef FWD_STATS_EN
    , input stallCnt, fwdCnt
`endif
  );

  modport slave (
    input  exValid, exRegWrite, exRd, exLat, exRs, flush,
    output fwdSel, stall
`ifdef FWD_STATS_EN
    , output stallCnt, fwdCnt
`endif
  );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding and hazard unit for the pipelined CPU.
// Tracks destination tags of instructions that have left EX in a shift
// pipeline (tags[0] = MEM stage, tags[DEPTH-1] = oldest). Each tag carries a
// countdown of cycles until its result can be forwarded. For every EX source
// operand the youngest matching producer decides: forward if ready, stall if
// not, otherwise read the register file.
// Optional feature macro: FWD_STATS_EN adds saturating stall/forward counters.
module fwd_scoreboard_unit #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_scoreboard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [LAT_W-1:0]  lat;
  } tagT;

  tagT                      tags [DEPTH];
  tagT                      aged [DEPTH];
  tagT                      newTag;
  logic [NUM_SRC*SEL_W-1:0] fwdSel;
  logic [NUM_SRC-1:0]       srcWait;
  logic                     hazard;
  logic                     stall;
  logic                     push;

  // A producer only counts if it really writes a nonzero register that the
  // source names; x0 is never forwarded.
  function automatic logic tagMatch(input tagT t, input logic [REG_AW-1:0] rs);
    return t.vld && t.wr && (t.rd == rs) && (rs != '0);
  endfunction

  // Latency countdown saturates so an entry stays ready until it leaves.
  function automatic logic [LAT_W-1:0] decLat(input logic [LAT_W-1:0] l);
    return (l == '0) ? '0 : l - LAT_W'(1);
  endfunction

  // Per source, walk from the oldest stage to the youngest so the youngest
  // match overrides; an unready youngest match wins over an older ready one.
  always_comb begin
    fwdSel  = '0;
    srcWait = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (tagMatch(tags[k], bus.exRs[i*REG_AW +: REG_AW])) begin
          if (tags[k].lat == '0) begin
            fwdSel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
            srcWait[i]               = 1'b0;
          end else begin
            fwdSel[i*SEL_W +: SEL_W] = '0;
            srcWait[i]               = 1'b1;
          end
        end
      end
    end
  end

  // A killed or empty EX slot never stalls; only a live instruction that
  // still proceeds gets a real tag, everything else becomes a bubble.
  always_comb begin
    hazard = |srcWait;
    stall  = hazard && bus.exValid && !bus.flush;
    push   = bus.exValid && !bus.flush && !hazard;
    newTag = '0;
    if (push) begin
      newTag.vld = 1'b1;
      newTag.wr  = bus.exRegWrite && (bus.exRd != '0);
      newTag.rd  = bus.exRd;
      newTag.lat = bus.exLat;
    end
  end

  // Tags one step older, with their latency counted down, ready to shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      aged[k]     = tags[k];
      aged[k].lat = decLat(tags[k].lat);
    end
  end

  // Shift pipeline: older entries always advance (a stall does not freeze
  // them) and the entry leaving the last stage is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) tags[k] <= '0;
    end else begin
      tags[0] <= newTag;
      for (int k = 1; k < DEPTH; k++) tags[k] <= aged[k-1];
    end
  end

  assign bus.fwdSel = fwdSel;
  assign bus.stall  = stall;

`ifdef FWD_STATS_EN
  logic [31:0] stallCnt;
  logic [31:0] fwdCnt;
  logic        anyFwd;

  assign anyFwd = (fwdSel != '0) && bus.exValid;

  // Saturating event counters for stall cycles and forwarding cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (stall && (stallCnt != 32'hFFFF_FFFF)) stallCnt <= stallCnt + 32'd1;
      if (anyFwd && (fwdCnt != 32'hFFFF_FFFF)) fwdCnt <= fwdCnt + 32'd1;
    end
  end

  assign bus.stallCnt = stallCnt;
  assign bus.fwdCnt   = fwdCnt;
`endif

`ifndef SYNTHESIS
  // A latency at or beyond the tracked depth would let a producer drop out
  // before its result is forwardable, so it is rejected outright.
  always @(posedge clk) begin
    if (rst_n && bus.exValid && !bus.flush) begin
      assert (int'(bus.exLat) < DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit.
// A queue-based model records every instruction that left EX together with
// the cycle it left; its stage and remaining latency follow from the cycle
// count. A compare process checks the DUT against that model every cycle,
// and directed steps pin hand-computed literal expectations.
module tb_fwd_scoreboard_unit;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int REG_AW  = 5;
  localparam int LAT_W   = 2;
  localparam int SEL_W   = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fwd_scoreboard_unit_if #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)
  ) bus ();

  fwd_scoreboard_unit #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic              wr;
    logic [REG_AW-1:0] rd;
    int                lat;
  } recT;

  recT hist[$];
  int  cycle;
  int  modelStallCnt;
  int  modelFwdCnt;

  // Youngest matching in-flight producer decides; its age in stages past
  // MEM tells whether its latency has elapsed.
  function automatic void modelPredict(input logic valid, input logic fl,
                                       input logic [NUM_SRC*REG_AW-1:0] rsVec,
                                       output logic [NUM_SRC*SEL_W-1:0] selVec,
                                       output logic stallOut);
    logic              haz;
    logic [REG_AW-1:0] rs;
    int                best;
    int                age;
    haz    = 1'b0;
    selVec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs   = rsVec[i*REG_AW +: REG_AW];
      best = -1;
      if (rs != '0) begin
        for (int h = 0; h < hist.size(); h++) begin
          age = cycle - hist[h].cyc - 1;
          if (age < DEPTH && hist[h].wr && hist[h].rd == rs) best = h;
        end
      end
      if (best >= 0) begin
        age = cycle - hist[best].cyc - 1;
        if (age >= hist[best].lat) selVec[i*SEL_W +: SEL_W] = SEL_W'(age + 1);
        else haz = 1'b1;
      end
    end
    stallOut = haz && valid && !fl;
  endfunction

  // Model update on each clock: record what left EX, age everything.
  always @(posedge clk or negedge rst_n) begin
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stl;
    if (!rst_n) begin
      hist.delete();
      cycle         = 0;
      modelStallCnt = 0;
      modelFwdCnt   = 0;
    end else begin
      modelPredict(bus.exValid, bus.flush, bus.exRs, sel, stl);
      if (stl) modelStallCnt++;
      if (sel != '0 && bus.exValid) modelFwdCnt++;
      if (bus.exValid && !bus.flush && !stl && !(sel == '0 && 1'b0)) begin
        if (!(|{stl})) begin
          hist.push_back('{cyc: cycle, wr: bus.exRegWrite && bus.exRd != '0,
                           rd: bus.exRd, lat: int'(bus.exLat)});
        end
      end
      cycle++;
      while (hist.size() > 0 && (cycle - hist[0].cyc - 1) >= DEPTH) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stl;
    modelPredict(bus.exValid, bus.flush, bus.exRs, sel, stl);
    for (int i = 0; i < NUM_SRC; i++) begin
      checks++;
      if (bus.fwdSel[i*SEL_W +: SEL_W] !== sel[i*SEL_W +: SEL_W]) begin
        failures++;
        $display("[TB] FAIL cmp_sel src%0d t=%0t got=%0d want=%0d", i, $time,
                 bus.fwdSel[i*SEL_W +: SEL_W], sel[i*SEL_W +: SEL_W]);
      end
    end
    checks++;
    if (bus.stall !== stl) begin
      failures++;
      $display("[TB] FAIL cmp_stall t=%0t got=%0b want=%0b", $time, bus.stall, stl);
    end
`ifdef FWD_STATS_EN
    checks++;
    if (bus.stallCnt !== 32'(modelStallCnt)) begin
      failures++;
      $display("[TB] FAIL cmp_stallcnt got=%0d want=%0d", bus.stallCnt, modelStallCnt);
    end
    checks++;
    if (bus.fwdCnt !== 32'(modelFwdCnt)) begin
      failures++;
      $display("[TB] FAIL cmp_fwdcnt got=%0d want=%0d", bus.fwdCnt, modelFwdCnt);
    end
`endif
  end

  // Drive one EX-stage instruction just after the active edge.
  task automatic applyStimulus(input logic valid, input logic rw,
                               input logic [REG_AW-1:0] rd, input logic [LAT_W-1:0] lat,
                               input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic fl);
    @(posedge clk);
    #1;
    bus.exValid    = valid;
    bus.exRegWrite = rw;
    bus.exRd       = rd;
    bus.exLat      = lat;
    bus.exRs       = {rs2, rs1};
    bus.flush      = fl;
  endtask

  // Compare the outputs right now against literal expectations.
  task automatic checkOutput(input string name, input int sel0, input int sel1,
                             input logic expStall);
    checks++;
    if (bus.fwdSel[0 +: SEL_W] !== SEL_W'(sel0)) begin
      failures++;
      $display("[TB] FAIL %s sel0 got=%0d want=%0d", name, bus.fwdSel[0 +: SEL_W], sel0);
    end
    checks++;
    if (bus.fwdSel[SEL_W +: SEL_W] !== SEL_W'(sel1)) begin
      failures++;
      $display("[TB] FAIL %s sel1 got=%0d want=%0d", name, bus.fwdSel[SEL_W +: SEL_W], sel1);
    end
    checks++;
    if (bus.stall !== expStall) begin
      failures++;
      $display("[TB] FAIL %s stall got=%0b want=%0b", name, bus.stall, expStall);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.exValid    = 1'b0;
    bus.exRegWrite = 1'b0;
    bus.exRd       = '0;
    bus.exLat      = '0;
    bus.exRs       = '0;
    bus.flush      = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); checkOutput("reset_state", 0, 0, 1'b0);

    // Reset while a load sits in MEM.
    applyStimulus(1, 1, 14, 1, 0, 0, 0);  @(negedge clk); checkOutput("rst_load_issue", 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 14, 0, 0);  @(negedge clk); checkOutput("rst_pre_stall", 0, 0, 1'b1);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_async", 0, 0, 1'b0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); checkOutput("rst_after", 0, 0, 1'b0);

    // ALU chain.
    applyStimulus(1, 1, 5, 0, 0, 0, 0);   @(negedge clk); checkOutput("alu_issue", 0, 0, 1'b0);
    applyStimulus(1, 1, 6, 0, 5, 0, 0);   @(negedge clk); checkOutput("alu_fwd_mem", 1, 0, 1'b0);
    applyStimulus(1, 1, 8, 0, 5, 0, 0);   @(negedge clk); checkOutput("alu_fwd_wb", 2, 0, 1'b0);

    // Load-use.
    applyStimulus(1, 1, 7, 1, 0, 0, 0);   @(negedge clk); checkOutput("lu_issue", 0, 0, 1'b0);
    applyStimulus(1, 1, 9, 0, 0, 7, 0);   @(negedge clk); checkOutput("lu_stall", 0, 0, 1'b1);
    applyStimulus(1, 1, 9, 0, 0, 7, 0);   @(negedge clk); checkOutput("lu_fwd", 0, 2, 1'b0);

    // Double producer: youngest wins.
    applyStimulus(1, 1, 3, 0, 0, 0, 0);   @(negedge clk); checkOutput("dbl_issue_a", 0, 0, 1'b0);
    applyStimulus(1, 1, 3, 0, 3, 0, 0);   @(negedge clk); checkOutput("dbl_first", 1, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 3, 0, 0);   @(negedge clk); checkOutput("dbl_young", 1, 0, 1'b0);
    applyStimulus(1, 1, 3, 0, 0, 0, 0);   @(negedge clk); checkOutput("dbl_issue_b", 0, 0, 1'b0);
    applyStimulus(1, 1, 3, 1, 0, 0, 0);   @(negedge clk); checkOutput("dbl_issue_ld", 0, 0, 1'b0);
    applyStimulus(1, 1, 10, 0, 3, 0, 0);  @(negedge clk); checkOutput("dbl_young_wait", 0, 0, 1'b1);
    applyStimulus(1, 1, 10, 0, 3, 0, 0);  @(negedge clk); checkOutput("dbl_release", 2, 0, 1'b0);

    // Non-writing producers and x0.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);   @(negedge clk); checkOutput("x0_issue", 0, 0, 1'b0);
    applyStimulus(1, 0, 4, 0, 0, 0, 0);   @(negedge clk); checkOutput("zero_regs", 0, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 4, 0, 0);   @(negedge clk); checkOutput("nowrite", 0, 0, 1'b0);

    // Flush during a load-use hazard.
    applyStimulus(1, 1, 12, 1, 0, 0, 0);  @(negedge clk); checkOutput("fl_issue", 0, 0, 1'b0);
    applyStimulus(1, 1, 13, 0, 12, 0, 1); @(negedge clk); checkOutput("flush_hazard", 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 13, 12, 0); @(negedge clk); checkOutput("flush_after", 0, 2, 1'b0);

    // Two-cycle latency producer.
    applyStimulus(1, 1, 15, 2, 0, 0, 0);  @(negedge clk); checkOutput("lat2_issue", 0, 0, 1'b0);
    applyStimulus(1, 1, 16, 0, 15, 0, 0); @(negedge clk); checkOutput("lat2_s1", 0, 0, 1'b1);
    applyStimulus(1, 1, 16, 0, 15, 0, 0); @(negedge clk); checkOutput("lat2_s2", 0, 0, 1'b1);
    applyStimulus(1, 1, 16, 0, 15, 0, 0); @(negedge clk); checkOutput("lat2_fwd", 3, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 16, 0);  @(negedge clk); checkOutput("src2_mem", 0, 1, 1'b0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
